// File: rtl/i2c_gain_master_if.sv
// Bus bundle for i2c_gain_master: transaction request/response plus the open-drain pin pair.
interface i2c_gain_master_if #(
  parameter int GAIN_W = 6
);
  logic              ena;
  logic              start;
  logic              rw;
  logic [6:0]        dev_addr;
  logic [7:0]        reg_addr;
  logic [GAIN_W-1:0] wr_data;
  logic [GAIN_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              ack_err;
  logic              SCL_in;
  logic              SDA_in;
  logic              SCL_out;
  logic              SDA_out;
  logic              SCL_ena;
  logic              SDA_ena;

  modport master (
    input  ena, start, rw, dev_addr, reg_addr, wr_data, SCL_in, SDA_in,
    output rd_data, busy, done, ack_err, SCL_out, SDA_out, SCL_ena, SDA_ena
  );

  modport slave (
    output ena, start, rw, dev_addr, reg_addr, wr_data, SCL_in, SDA_in,
    input  rd_data, busy, done, ack_err, SCL_out, SDA_out, SCL_ena, SDA_ena
  );
endinterface

// File: rtl/i2c_gain_master.sv
// I2C controller that writes/reads one PID gain register per start request.
// Optional SCL clock stretching is enabled by defining I2C_CLOCK_STRETCH_EN.
module i2c_gain_master #(
  parameter int CLK_DIV = 4,
  parameter int GAIN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_gain_master_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK1, REG, ACK2, WDATA, ACK3,
    RSTART, ADDR_R, ACK4, RDATA, MNACK, STOP, DONE
  } state_t;

  localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

  state_t            state, state_nxt;
  logic [7:0]        qcnt;
  logic [1:0]        quarter;
  logic [2:0]        bit_idx;
  logic              rw_q;
  logic [6:0]        dev_q;
  logic [7:0]        reg_q;
  logic [GAIN_W-1:0] wr_q;
  logic [7:0]        rx, rx_next, tx_byte;
  logic              ack_err_q;
  logic [GAIN_W-1:0] rd_q;
  logic              scl_ena, sda_ena;
  logic              in_txn, capture, stall, bit_end, sample, is_byte, is_ack;

  assign in_txn  = (state != IDLE) && (state != DONE);
  assign capture = bus.ena && bus.start && !in_txn;
`ifdef I2C_CLOCK_STRETCH_EN
  // A target holding SCL low while we release it freezes the bit clock.
  assign stall   = (quarter == 2'd1) && !scl_ena && !bus.SCL_in;
`else
  assign stall   = 1'b0;
`endif
  assign bit_end = bus.ena && in_txn && !stall && (quarter == 2'd3) && (qcnt == QMAX);
  assign sample  = bus.ena && in_txn && (quarter == 2'd2) && (qcnt == 8'd0);
  assign is_byte = state inside {ADDR_W, REG, WDATA, ADDR_R, RDATA};
  assign is_ack  = state inside {ACK1, ACK2, ACK3, ACK4};
  assign rx_next = {rx[6:0], bus.SDA_in};

  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      ADDR_W:  tx_byte = {dev_q, 1'b0};
      REG:     tx_byte = reg_q;
      WDATA:   tx_byte = 8'(wr_q);
      ADDR_R:  tx_byte = {dev_q, 1'b1};
      default: tx_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      qcnt      <= '0;
      quarter   <= '0;
      bit_idx   <= '0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wr_q      <= '0;
      rx        <= '0;
      ack_err_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        rw_q      <= bus.rw;
        dev_q     <= bus.dev_addr;
        reg_q     <= bus.reg_addr;
        wr_q      <= bus.wr_data;
        ack_err_q <= 1'b0;
        qcnt      <= '0;
        quarter   <= '0;
        bit_idx   <= '0;
      end else if (bus.ena && in_txn && !stall) begin
        qcnt <= (qcnt == QMAX) ? 8'd0 : qcnt + 8'd1;
        if (qcnt == QMAX) quarter <= quarter + 2'd1;
        if (bit_end && is_byte) bit_idx <= bit_idx + 3'd1;
      end
      if (sample && is_ack && bus.SDA_in) ack_err_q <= 1'b1;
      if (sample && state == RDATA) begin
        rx <= rx_next;
        if (bit_idx == 3'd7) rd_q <= rx_next[GAIN_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    scl_ena   = 1'b0;
    sda_ena   = 1'b0;
    case (state)
      IDLE:   if (capture) state_nxt = START;
      DONE:   if (capture) state_nxt = START; else if (bus.ena) state_nxt = IDLE;
      START:  if (bit_end) state_nxt = ADDR_W;
      ADDR_W: if (bit_end && bit_idx == 3'd7) state_nxt = ACK1;
      ACK1:   if (bit_end) state_nxt = ack_err_q ? STOP : REG;
      REG:    if (bit_end && bit_idx == 3'd7) state_nxt = ACK2;
      ACK2:   if (bit_end) state_nxt = ack_err_q ? STOP : (rw_q ? RSTART : WDATA);
      WDATA:  if (bit_end && bit_idx == 3'd7) state_nxt = ACK3;
      ACK3:   if (bit_end) state_nxt = STOP;
      RSTART: if (bit_end) state_nxt = ADDR_R;
      ADDR_R: if (bit_end && bit_idx == 3'd7) state_nxt = ACK4;
      ACK4:   if (bit_end) state_nxt = ack_err_q ? STOP : RDATA;
      RDATA:  if (bit_end && bit_idx == 3'd7) state_nxt = MNACK;
      MNACK:  if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase

    case (state)
      IDLE, DONE: ;
      STOP: begin
        scl_ena = (quarter == 2'd0);
        sda_ena = (quarter <= 2'd1);
      end
      default: begin
        scl_ena = (quarter == 2'd0) || (quarter == 2'd3);
        // Ack, read-data and master-NACK slots see tx_byte = FF, i.e. SDA released.
        if (state == START || state == RSTART) sda_ena = (quarter >= 2'd2);
        else                                   sda_ena = !tx_byte[~bit_idx];
      end
    endcase
  end

  assign bus.busy    = in_txn;
  assign bus.done    = (state == DONE);
  assign bus.ack_err = ack_err_q;
  assign bus.rd_data = rd_q;
  assign bus.SCL_ena = scl_ena;
  assign bus.SDA_ena = sda_ena;
  assign bus.SCL_out = 1'b0;
  assign bus.SDA_out = 1'b0;
endmodule
